// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types, defaults and majority helper for the vote arbiter
//
// Purpose : FSM state encoding, parameter defaults and the gate-level
//           2-of-3 majority function used by vote_arbiter.
// Ports   : none (package)
package vote_pkg;

   localparam int N_REQ_DEF = 3;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   // t = {in2, in1, in0}
   function automatic logic maj3(input logic [2:0] t);
      return ((t[0] | t[1]) & t[2]) | (t[0] & t[1]);
   endfunction

endpackage

// File: rtl/vote_rr_sel.sv
// rtl/vote_rr_sel.sv - three-way round-robin grant selector
//
// Purpose : picks the first valid requester at or after ptr, wrapping 2->0.
// Ports   : req_val   [2:0] in  - requester valid bits
//           ptr       [1:0] in  - search start index (0..2)
//           grant     [2:0] out - one-hot grant, zero when nothing is valid
//           grant_idx [1:0] out - encoded index of the granted requester
module vote_rr_sel
   import vote_pkg::*;
(
   input  logic [2:0] req_val,
   input  logic [1:0] ptr,
   output logic [2:0] grant,
   output logic [1:0] grant_idx
);

   logic       found;
   logic [2:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < 3; k++) begin
         // ptr + k stays below 5, so one conditional subtract gives mod 3
         cand = {1'b0, ptr} + 3'(k);
         if (cand >= 3'd3) begin
            cand = cand - 3'd3;
         end
         if (!found && req_val[cand[1:0]]) begin
            found                 = 1'b1;
            grant[cand[1:0]]      = 1'b1;
            grant_idx             = cand[1:0];
         end
      end
   end

endmodule

// File: rtl/vote_arbiter.sv
// rtl/vote_arbiter.sv - round-robin arbiter returning a 2-of-3 majority per request
//
// Purpose : grants one of three requesters, computes the majority of its
//           triple, holds the result until accepted, counts accepted hits.
// Ports   : clk, rst_n        in  - clock, synchronous active-low reset
//           req_val  [N-1:0]  in  - requester valid
//           req_data [3N-1:0] in  - requester i triple at [3i+2:3i]
//           req_rdy  [N-1:0]  out - one-hot grant (IDLE only)
//           resp_val/id/out   out - registered result, zeroed when not valid
//           resp_rdy          in  - consumer accepts the result
//           hit_cnt  [W-1:0]  out - saturating count of accepted 1-results
module vote_arbiter
   import vote_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,   // only 3 is supported
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_val,
   input  logic [3*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_rdy,
   output logic               resp_val,
   output logic [1:0]         resp_id,
   output logic               resp_out,
   input  logic               resp_rdy,
   output logic [CNT_W-1:0]   hit_cnt
);

   state_t           state_q;
   logic [1:0]       ptr_q, ptr_d;
   logic             resp_val_q;
   logic [1:0]       resp_id_q;
   logic             resp_out_q;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

   logic [2:0]       grant;
   logic [1:0]       grant_idx;
   logic [2:0]       triple;
   logic             xfer;

   vote_rr_sel u_sel (
      .req_val   (req_val),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grants are only visible while idle and out of reset.
   assign req_rdy = (state_q == IDLE && rst_n) ? grant : '0;
   assign xfer    = |(req_val & req_rdy);

   always_comb begin
      triple = req_data[2:0];
      case (grant_idx)
         2'd1:    triple = req_data[5:3];
         2'd2:    triple = req_data[8:6];
         default: triple = req_data[2:0];
      endcase
   end

   assign ptr_d     = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
   assign hit_cnt_d = (resp_out_q && (hit_cnt_q != {CNT_W{1'b1}}))
                      ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         resp_val_q <= 1'b0;
         resp_id_q  <= '0;
         resp_out_q <= 1'b0;
         hit_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  state_q    <= RESP;
                  ptr_q      <= ptr_d;
                  resp_val_q <= 1'b1;
                  resp_id_q  <= grant_idx;
                  resp_out_q <= maj3(triple);
               end
            end
            RESP: begin
               // Accept cycle returns to IDLE without granting, so the
               // next grant appears one cycle later.
               if (resp_rdy) begin
                  state_q    <= IDLE;
                  resp_val_q <= 1'b0;
                  resp_id_q  <= '0;
                  resp_out_q <= 1'b0;
                  hit_cnt_q  <= hit_cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_val = resp_val_q;
   assign resp_id  = resp_id_q;
   assign resp_out = resp_out_q;
   assign hit_cnt  = hit_cnt_q;

endmodule

// File: tb/tb_vote_arbiter.sv
// tb/tb_vote_arbiter.sv - directed self-checking bench for vote_arbiter
module tb_vote_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req_val;
   logic [8:0] req_data;
   logic [2:0] req_rdy;
   logic       resp_val;
   logic [1:0] resp_id;
   logic       resp_out;
   logic       resp_rdy;
   logic [7:0] hit_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vote_arbiter #(.N_REQ(3), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_val  (req_val),
      .req_data (req_data),
      .req_rdy  (req_rdy),
      .resp_val (resp_val),
      .resp_id  (resp_id),
      .resp_out (resp_out),
      .resp_rdy (resp_rdy),
      .hit_cnt  (hit_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with resp_rdy=1: grant, one-cycle result, accept.
   task automatic xfer(input string tag, input logic [2:0] val, input logic [8:0] data,
                       input logic [2:0] exp_gnt, input logic [1:0] exp_id, input logic exp_out);
      req_val  = val;
      req_data = data;
      resp_rdy = 1'b1;
      #1;
      chk({tag, "_gnt"}, 32'(req_rdy), 32'(exp_gnt));
      cyc();
      chk({tag, "_val"}, 32'(resp_val), 32'd1);
      chk({tag, "_id"},  32'(resp_id),  32'(exp_id));
      chk({tag, "_out"}, 32'(resp_out), 32'(exp_out));
      chk({tag, "_rdy0"}, 32'(req_rdy), 32'd0);
      cyc();
      chk({tag, "_done"}, 32'(resp_val), 32'd0);
   endtask

   logic [7:0] maj_tbl;
   logic [2:0] onehot;

   initial begin
      maj_tbl  = 8'b1110_1000;
      rst_n    = 1'b0;
      req_val  = 3'b111;
      req_data = '0;
      resp_rdy = 1'b0;
      cyc();
      cyc();
      chk("rst_rdy", 32'(req_rdy),  32'd0);
      chk("rst_val", 32'(resp_val), 32'd0);
      chk("rst_id",  32'(resp_id),  32'd0);
      chk("rst_out", 32'(resp_out), 32'd0);
      chk("rst_hit", 32'(hit_cnt),  32'd0);
      rst_n = 1'b1;

      // Basic transfer, triple0 = 011
      xfer("basic", 3'b001, 9'b000_000_011, 3'b001, 2'd0, 1'b1);
      chk("basic_hit", 32'(hit_cnt), 32'd1);

      // Requester 2 moves ptr back to 0
      xfer("ptr0", 3'b100, 9'd0, 3'b100, 2'd2, 1'b0);

      // Rotation 0,1,2,0 with all requesters valid
      for (int i = 0; i < 4; i++) begin
         onehot = 3'b001 << (i % 3);
         xfer("rot", 3'b111, 9'd0, onehot, 2'(i % 3), 1'b0);
      end
      chk("rot_hit", 32'(hit_cnt), 32'd1);

      // Backpressure: ptr=1, triple1=110, hold resp_rdy=0 for 5 cycles
      req_val  = 3'b010;
      req_data = 9'b000_110_000;
      resp_rdy = 1'b0;
      #1;
      chk("bp_gnt", 32'(req_rdy), 32'b010);
      cyc();
      req_val = 3'b111;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_val", 32'(resp_val), 32'd1);
         chk("bp_id",  32'(resp_id),  32'd1);
         chk("bp_out", 32'(resp_out), 32'd1);
         chk("bp_rdy", 32'(req_rdy),  32'd0);
         cyc();
      end
      resp_rdy = 1'b1;
      req_val  = 3'b000;
      cyc();
      chk("bp_done", 32'(resp_val), 32'd0);
      chk("bp_hit",  32'(hit_cnt),  32'd2);

      // All 8 triples through requester 2
      for (int v = 0; v < 8; v++) begin
         xfer("maj", 3'b100, 9'(v << 6), 3'b100, 2'd2, maj_tbl[v]);
      end
      chk("maj_hit", 32'(hit_cnt), 32'd6);

      // Clean reset, then reset while holding a pending 1-result
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("rst2_hit", 32'(hit_cnt), 32'd0);
      req_val  = 3'b010;
      req_data = 9'b000_111_000;
      resp_rdy = 1'b0;
      #1;
      chk("rr_gnt", 32'(req_rdy), 32'b010);
      cyc();
      chk("rr_val", 32'(resp_val), 32'd1);
      chk("rr_out", 32'(resp_out), 32'd1);
      rst_n   = 1'b0;
      req_val = 3'b111;
      #1;
      chk("rr_rdy_rst", 32'(req_rdy), 32'd0);
      cyc();
      chk("rr_val0", 32'(resp_val), 32'd0);
      chk("rr_out0", 32'(resp_out), 32'd0);
      chk("rr_hit0", 32'(hit_cnt),  32'd0);
      rst_n = 1'b1;
      xfer("rr_ptr", 3'b111, 9'd0, 3'b001, 2'd0, 1'b0);
      chk("rr_hit1", 32'(hit_cnt), 32'd0);

      // Saturation: 254 quiet hits, then 255th, then one more
      req_val  = 3'b001;
      req_data = 9'b000_000_111;
      resp_rdy = 1'b1;
      for (int i = 0; i < 254; i++) begin
         cyc();
         cyc();
      end
      chk("sat_254", 32'(hit_cnt), 32'd254);
      xfer("sat_a", 3'b001, 9'b000_000_111, 3'b001, 2'd0, 1'b1);
      chk("sat_255", 32'(hit_cnt), 32'd255);
      xfer("sat_b", 3'b001, 9'b000_000_111, 3'b001, 2'd0, 1'b1);
      chk("sat_hold", 32'(hit_cnt), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
